// File: rtl/dmux_rr_sched.sv
// dmux_rr_sched
//   Packet-level round-robin scheduler for a 1x4 demultiplexer. Each whole
//   packet from a single valid/ready source is steered to one of four sinks.
//   Destinations whose dest_en bit is clear are skipped. One registered
//   output stage is shared by all four ports.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_data/in_last/in_ready   source beat handshake
//   dest_en[3:0]            per-destination enable, sampled only at packet pick
//   out_valid[3:0]          one-hot valid toward the selected sink
//   out_data, out_last      registered beat data and last flag (shared)
//   out_ready[3:0]          per-destination ready (only the selected one is used)
//   s1, s0                  demux select, stable for the whole packet
//   pkt_done                1-cycle pulse when the last beat leaves the output stage
//   pkt_port, pkt_len       destination and beat count of the completed packet
module dmux_rr_sched #(
  parameter int W     = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [3:0]       dest_en,
  output logic [3:0]       out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  input  logic [3:0]       out_ready,
  output logic             s1,
  output logic             s0,
  output logic             pkt_done,
  output logic [1:0]       pkt_port,
  output logic [LEN_W-1:0] pkt_len
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t           state;
  logic [1:0]       sel;
  logic [1:0]       last_sel;
  logic             out_vld;
  logic [LEN_W-1:0] beat_cnt;
  logic             sel_ready;
  logic             drain_fire;
  logic             accept;

  // First enabled port after the previous winner, wrapping back to it last.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] en);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && en[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    sat_inc = (&c) ? c : c + LEN_W'(1);
  endfunction

  assign sel_ready  = out_ready[sel];
  assign drain_fire = out_vld & sel_ready;
  // Single output register: a new beat may enter when the slot is empty or
  // is being emptied this cycle.
  assign in_ready   = (state == BUSY) & (~out_vld | sel_ready);
  assign accept     = in_valid & in_ready;

  assign out_valid  = {4{out_vld}} & (4'b0001 << sel);
  assign s1         = sel[1];
  assign s0         = sel[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      last_sel <= 2'd3;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      pkt_done <= 1'b0;
      pkt_port <= 2'd0;
      pkt_len  <= '0;
      beat_cnt <= '0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && (|dest_en)) begin
            sel      <= rr_pick(last_sel, dest_en);
            last_sel <= rr_pick(last_sel, dest_en);
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // output stage
          if (accept) begin
            out_data <= in_data;
            out_last <= in_last;
            out_vld  <= 1'b1;
            beat_cnt <= sat_inc(beat_cnt);
            if (in_last) state <= DRAIN;
          end else if (drain_fire) begin
            out_vld <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            out_vld  <= 1'b0;
            pkt_done <= 1'b1;
            pkt_port <= sel;
            pkt_len  <= beat_cnt;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
